fifo_loader: RTL

- Host-side writer for a 12-bit CPU input FIFO.
- Takes a byte stream from the host link, usually a UART receiver, and assembles 12-bit words from two-byte frames.
- Drives the FIFO's write port (data_write / data_in) and tracks FIFO occupancy so a 256-entry FIFO is never overwritten.
- Decodes a clear command that resets the FIFO and the loader together.

---
 rtl/fifo_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_loader.sv
// fifo_loader: assembles 12-bit words from two-byte host frames and writes
// them into a downstream 2^DEPTH_LOG2-entry FIFO. It tracks occupancy so the
// FIFO is never overrun, and it decodes the CLEAR command (0xC0).
// Optional build macro: FIFO_LOADER_WCOUNT_EN adds the saturating 16-bit
// words_loaded counter output.
module fifo_loader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  rd_pop,
  output logic                  data_write,
  output logic [11:0]           data_in,
  output logic                  fifo_clr,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
`ifdef FIFO_LOADER_WCOUNT_EN
  output logic [15:0]           words_loaded,
`endif
  output logic                  frame_err
);

  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {IDLE, HAVE_HI} state_t;

  state_t     state_q, state_d;
  logic [5:0] hi_reg;
  logic       accept;
  logic       is_hi, is_lo, is_clr;
  logic       hi_load, frame_done, clear_cmd, set_err;
  logic       pop_ok;

  assign full   = (level == LEVEL_MAX);
  assign pop_ok = rd_pop && (level != '0);

  // Handshake, byte classification and next-state decode
  always_comb begin
    state_d    = state_q;
    hi_load    = 1'b0;
    frame_done = 1'b0;
    clear_cmd  = 1'b0;
    set_err    = 1'b0;
    // LO bytes stall only in HAVE_HI; IDLE may always take HI or command bytes.
    byte_ready = rst_n && !fifo_clr && ((state_q == IDLE) || !full);
    accept     = byte_valid && byte_ready;
    is_hi      = (byte_data[7:6] == 2'b10);
    is_lo      = !byte_data[7];
    is_clr     = (byte_data == 8'hC0);
    if (accept) begin
      if (is_clr) begin
        state_d   = IDLE;
        clear_cmd = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_hi) begin
              state_d = HAVE_HI;
              hi_load = 1'b1;
            end else if (is_lo) begin
              set_err = 1'b1;
            end
          end
          HAVE_HI: begin
            if (is_lo) begin
              state_d    = IDLE;
              frame_done = 1'b1;
            end else if (is_hi) begin
              hi_load = 1'b1;
              set_err = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Upper six bits of the word being assembled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hi_reg <= '0;
    else if (hi_load) hi_reg <= byte_data[5:0];
  end

  // FIFO write port and clear strobe, one cycle after the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_write <= 1'b0;
      data_in    <= '0;
      fifo_clr   <= 1'b0;
    end else begin
      data_write <= frame_done;
      fifo_clr   <= clear_cmd;
      if (frame_done) data_in <= {hi_reg, byte_data[5:0]};
    end
  end

  // Occupancy: counted at frame completion so full is exact; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (clear_cmd) begin
      level <= '0;
    end else if (!fifo_clr) begin
      case ({frame_done, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky framing error, cleared only by reset or CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_err <= 1'b0;
    else if (clear_cmd) frame_err <= 1'b0;
    else if (set_err)   frame_err <= 1'b1;
  end

`ifdef FIFO_LOADER_WCOUNT_EN
  // Saturating count of words written since reset or the last CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      words_loaded <= '0;
    else if (clear_cmd)
      words_loaded <= '0;
    else if (data_write && (words_loaded != 16'hFFFF))
      words_loaded <= words_loaded + 16'd1;
  end
`endif

endmodule
